minibus_master: RTL

- Initiator end of the minibus: turns a single CPU load/store request into one minibus transaction.
- Holds the request on the bus until the selected slave acks, then returns data or error to the CPU.
- Sits between the CPU data-memory port and the minibus interconnect/decoder that drives slave `sel`.
- Handles misalignment checks and load sign/zero extension, so slaves only see naturally aligned accesses.

---
 rtl/minibus_master_pkg.sv | 20 ++
 rtl/minibus_load_ext.sv | 25 ++
 rtl/minibus_master.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/minibus_master_pkg.sv
// Shared types for the minibus initiator: access widths, FSM states and the word type.
package minibus_master_pkg;

   localparam int BIT_WIDTH = 32;

   typedef logic [BIT_WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_width_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } minibus_mstate_t;

endpackage

// File: rtl/minibus_load_ext.sv
// Load extension: widens a right-aligned byte/half to a full word, signed unless width[2] is set.
module minibus_load_ext
   import minibus_master_pkg::*;
#(
   parameter int DATA_W = BIT_WIDTH
) (
   input  logic [2:0]        i_width,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_data
);

   logic w_signed;

   assign w_signed = ~i_width[2];

   always_comb begin
      o_data = i_rdata;
      case (i_width[1:0])
         BYTE:    o_data = {{(DATA_W-8){w_signed & i_rdata[7]}}, i_rdata[7:0]};
         HALF:    o_data = {{(DATA_W-16){w_signed & i_rdata[15]}}, i_rdata[15:0]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/minibus_master.sv
// Minibus initiator: one CPU load/store becomes one held bus request, then a one-cycle response.
// Define MINIBUS_MASTER_TIMEOUT_EN to force an error after TIMEOUT_CYC unacknowledged ACCESS cycles.
module minibus_master
   import minibus_master_pkg::*;
#(
   parameter int ADDR_W = BIT_WIDTH,
   parameter int DATA_W = BIT_WIDTH
`ifdef MINIBUS_MASTER_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_ren,
   input  logic              i_cpu_wen,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [2:0]        i_cpu_width,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_ready,
   output logic              o_cpu_err,
   output logic              o_bus_ren,
   output logic              o_bus_wen,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [2:0]        o_bus_width,
   output logic [DATA_W-1:0] o_bus_wdata,
   input  logic              i_bus_ack,
   input  logic              i_bus_err,
   input  logic [DATA_W-1:0] i_bus_rdata
);

   minibus_mstate_t   r_state;
   logic              r_ren;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_width;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_ready;
   logic              r_err;

   logic [DATA_W-1:0] w_ext;
   logic              w_req;
   logic              w_reject;
   logic              w_misaligned;
   logic              w_timeout;

   // Anything a slave must never see is answered locally with an error.
   assign w_req        = i_cpu_ren | i_cpu_wen;
   assign w_misaligned = ((i_cpu_width[1:0] == HALF) && i_cpu_addr[0]) ||
                         ((i_cpu_width[1:0] == WORD) && (i_cpu_addr[1:0] != 2'b00));
   assign w_reject     = (i_cpu_ren & i_cpu_wen) || (i_cpu_width[1:0] == 2'b11) || w_misaligned;

   minibus_load_ext #(.DATA_W(DATA_W)) u_load_ext (
      .i_width (r_width),
      .i_rdata (i_bus_rdata),
      .o_data  (w_ext)
   );

`ifdef MINIBUS_MASTER_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] r_count;

   // Counts completed ACCESS cycles; the cycle that would reach TIMEOUT_CYC is the last one.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (r_state != ACCESS) begin
         r_count <= '0;
      end else if (!i_bus_ack) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_width <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_rdata <= '0;
               if (w_req) begin
                  if (w_reject) begin
                     r_ready <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end else begin
                     r_ren   <= i_cpu_ren;
                     r_wen   <= i_cpu_wen;
                     r_addr  <= i_cpu_addr;
                     r_width <= i_cpu_width;
                     r_wdata <= i_cpu_wdata;
                     r_state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // An ack on the timeout cycle still completes normally.
               if (i_bus_ack) begin
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  r_ready <= 1'b1;
                  r_err   <= i_bus_err;
                  r_rdata <= (i_bus_err || r_wen) ? '0 : w_ext;
                  r_state <= RESP;
               end else if (w_timeout) begin
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  r_ready <= 1'b1;
                  r_err   <= 1'b1;
                  r_rdata <= '0;
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_rdata <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_bus_ren   = r_ren;
   assign o_bus_wen   = r_wen;
   assign o_bus_addr  = r_addr;
   assign o_bus_width = r_width;
   assign o_bus_wdata = r_wdata;
   assign o_cpu_rdata = r_rdata;
   assign o_cpu_ready = r_ready;
   assign o_cpu_err   = r_err;

endmodule
